program_loader: RTL

Writer side of the instruction store. Accepts a byte stream over a valid/ready handshake, packs consecutive bytes most-significant first into `InstructionSz`-bit instruction words, and issues one single-cycle write per word to a writable program memory at sequential addresses starting from 0. It sits between the host/debug byte channel and program memory, and keeps the core held (via `busy`) until the load completes.

---
 rtl/program_loader.sv | 131 +++++++++++++
 1 files changed

// File: rtl/program_loader.sv
// program_loader: packs a valid/ready byte stream (MSB first) into instruction
// words and writes them to program memory at sequential addresses from 0.
module program_loader #(
  parameter int unsigned AddrSz        = 6,
  parameter int unsigned InstructionSz = 24
) (
  input  logic                     clk,
  input  logic                     n_reset,
  input  logic                     start,
  input  logic [7:0]               byte_in,
  input  logic                     byte_valid,
  input  logic                     byte_last,
  output logic                     byte_ready,
  output logic                     wr_en,
  output logic [AddrSz-1:0]        wr_address,
  output logic [InstructionSz-1:0] wr_data,
  output logic                     busy,
  output logic                     done,
  output logic                     error,
  output logic [AddrSz:0]          words_loaded
);

  localparam int unsigned BytesPerWord = InstructionSz / 8;
  localparam int unsigned CntW         = (BytesPerWord > 1) ? $clog2(BytesPerWord) : 1;
  localparam logic [CntW-1:0]   LastByte = CntW'(BytesPerWord - 1);
  localparam logic [AddrSz-1:0] MaxAddr  = '1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_e;

  state_e                   state_q, state_d;
  logic [CntW-1:0]          cnt_q, cnt_d;
  logic [InstructionSz-1:0] data_q, data_d;
  logic [AddrSz-1:0]        addr_q, addr_d;
  logic [AddrSz:0]          words_q, words_d;
  logic                     err_q, err_d;
  logic                     last_q, last_d;
  logic                     accept;

  // State and datapath registers; reset abandons any load in flight.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      data_q  <= '0;
      addr_q  <= '0;
      words_q <= '0;
      err_q   <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      addr_q  <= addr_d;
      words_q <= words_d;
      err_q   <= err_d;
      last_q  <= last_d;
    end
  end

  // Next-state: byte packing, word write, termination and overflow handling.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    addr_d  = addr_q;
    words_d = words_q;
    err_d   = err_q;
    last_d  = last_q;
    accept  = byte_valid && (state_q == LOAD);

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = LOAD;
          cnt_d   = '0;
          addr_d  = '0;
          words_d = '0;
          err_d   = 1'b0;
          last_d  = 1'b0;
        end
      end
      LOAD: begin
        if (accept) begin
          data_d = (data_q << 8) | InstructionSz'(byte_in);
          if (cnt_q == LastByte) begin
            state_d = WRITE;
            last_d  = byte_last;
          end else if (byte_last) begin
            // Stream ended mid-word: drop the partial word.
            state_d = DONE;
            err_d   = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      WRITE: begin
        words_d = words_q + 1'b1;
        cnt_d   = '0;
        if (last_q) begin
          state_d = DONE;
          err_d   = 1'b0;
        end else if (addr_q == MaxAddr) begin
          // Memory full with the stream still open.
          state_d = DONE;
          err_d   = 1'b1;
        end else begin
          addr_d  = addr_q + 1'b1;
          state_d = LOAD;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Status and strobes decoded from the registered state only.
  assign byte_ready   = (state_q == LOAD);
  assign wr_en        = (state_q == WRITE);
  assign busy         = (state_q == LOAD) || (state_q == WRITE);
  assign done         = (state_q == DONE);
  assign error        = err_q;
  assign wr_address   = addr_q;
  assign wr_data      = data_q;
  assign words_loaded = words_q;

endmodule
